// File: rtl/bus_region_decoder.sv
// Registered bus region decoder: windowed target select with ack wait,
// timeout abort and error capture for unmapped or timed-out accesses.
module bus_region_decoder #(
  parameter int ADDR_W  = 11,
  parameter int NUM_TGT = 3,
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE =
    {11'h410, 11'h400, 11'h000},
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_LAST =
    {11'h41F, 11'h40F, 11'h3FF},
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               req_err,
  output logic [NUM_TGT-1:0] tgt_sel,
  input  logic [NUM_TGT-1:0] tgt_ack,
  output logic               busy,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [7:0]         err_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  logic [1:0]         state;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         cnt;
  logic [7:0]         cnt_nxt;
  logic               err_q;
  logic               ack_hit;
  logic [NUM_TGT-1:0] hit;
  logic [ADDR_W-1:0]  off;
  logic [ADDR_W-1:0]  span;

  // Offset-within-span compare avoids a constant ">= 0" for base-0 windows;
  // scanning downward lets the lowest matching index win.
  always_comb begin
    hit  = '0;
    off  = '0;
    span = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      off  = req_addr - TGT_BASE[i*ADDR_W +: ADDR_W];
      span = TGT_LAST[i*ADDR_W +: ADDR_W]
           - TGT_BASE[i*ADDR_W +: ADDR_W];
      if (off <= span) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  assign ack_hit   = |(tgt_ack & tgt_sel);
  assign cnt_nxt   = cnt + 8'd1;
  assign req_ready = (state == S_DONE);
  assign req_err   = req_ready & err_q;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      tgt_sel   <= '0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            cnt    <= '0;
            if (|hit) begin
              tgt_sel <= hit;
              err_q   <= 1'b0;
              state   <= S_ACCESS;
            end else begin
              err_q    <= 1'b1;
              err_addr <= req_addr;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              state    <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          cnt <= cnt_nxt;
          if (ack_hit) begin
            tgt_sel <= '0;
            err_q   <= 1'b0;
            state   <= S_DONE;
          end else if (cnt_nxt == TMO) begin
            tgt_sel  <= '0;
            err_q    <= 1'b1;
            err_addr <= addr_q;
            if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          tgt_sel <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder: decode, latency, timeout,
// ack race, error saturation, back-to-back and mid-access reset.
module tb_bus_region_decoder;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [10:0] req_addr;
  logic        req_ready;
  logic        req_err;
  logic [2:0]  tgt_sel;
  logic [2:0]  tgt_ack;
  logic        busy;
  logic [10:0] err_addr;
  logic [7:0]  err_count;

  int nvec = 0;
  int nerr = 0;

  bus_region_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .req_err   (req_err),
    .tgt_sel   (tgt_sel),
    .tgt_ack   (tgt_ack),
    .busy      (busy),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; ack pattern applied from the cycle after acceptance.
  task automatic run(input logic [10:0] a, input logic [2:0] ack,
                     output logic [2:0] sel, output logic er,
                     output int lat);
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    sel       = tgt_sel;
    req_valid = 1'b0;
    tgt_ack   = ack;
    lat       = 1;
    while (!req_ready && lat < 300) begin
      tick();
      lat++;
    end
    er      = req_err;
    tgt_ack = '0;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    tgt_ack   = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    nvec++;
    if ({req_ready, req_err, tgt_sel, busy} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_ctl got=%b want=000000",
               {req_ready, req_err, tgt_sel, busy});
    end
    nvec++;
    if (err_addr !== 11'h0 || err_count !== 8'h0) begin
      nerr++;
      $display("FAIL reset_err got=%h/%0d want=000/0",
               err_addr, err_count);
    end
  endtask

  task automatic test_basic();
    req_addr  = 11'h005;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    nvec++;
    if (tgt_sel !== 3'b001 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL basic_sel got=%b busy=%b want=001 busy=1",
               tgt_sel, busy);
    end
    tick();
    tick();
    nvec++;
    if (tgt_sel !== 3'b001 || req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL basic_hold got=%b rdy=%b want=001 rdy=0",
               tgt_sel, req_ready);
    end
    tgt_ack = 3'b001;
    tick();
    tgt_ack = '0;
    nvec++;
    if ({req_ready, req_err, tgt_sel} !== 5'b10000) begin
      nerr++;
      $display("FAIL basic_done got=%b want=10000",
               {req_ready, req_err, tgt_sel});
    end
    tick();
    nvec++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL basic_idle rdy=%b busy=%b want=0/0",
               req_ready, busy);
    end
  endtask

  task automatic test_decode();
    logic [10:0] addrs [6];
    logic [2:0]  exp   [6];
    logic [2:0]  sel;
    logic        er;
    int          lat;
    addrs = '{11'h40F, 11'h410, 11'h41F, 11'h3FF, 11'h400, 11'h000};
    exp   = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b010, 3'b001};
    for (int i = 0; i < 6; i++) begin
      run(addrs[i], exp[i], sel, er, lat);
      nvec++;
      if (sel !== exp[i] || er !== 1'b0 || lat != 2) begin
        nerr++;
        $display("FAIL decode_%h sel=%b er=%b lat=%0d want=%b/0/2",
                 addrs[i], sel, er, lat, exp[i]);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [2:0] sel;
    logic       er;
    int         lat;
    run(11'h420, 3'b000, sel, er, lat);
    nvec++;
    if (sel !== 3'b000 || er !== 1'b1 || lat != 1) begin
      nerr++;
      $display("FAIL unmapped sel=%b er=%b lat=%0d want=000/1/1",
               sel, er, lat);
    end
    nvec++;
    if (err_addr !== 11'h420 || err_count !== 8'd1) begin
      nerr++;
      $display("FAIL unmapped_log got=%h/%0d want=420/1",
               err_addr, err_count);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] sel;
    logic       er;
    int         lat;
    run(11'h400, 3'b100, sel, er, lat);
    nvec++;
    if (sel !== 3'b010 || er !== 1'b1 || lat != TMO + 1) begin
      nerr++;
      $display("FAIL timeout sel=%b er=%b lat=%0d want=010/1/%0d",
               sel, er, lat, TMO + 1);
    end
    nvec++;
    if (err_addr !== 11'h400 || err_count !== 8'd2) begin
      nerr++;
      $display("FAIL timeout_log got=%h/%0d want=400/2",
               err_addr, err_count);
    end
  endtask

  task automatic test_race();
    req_addr  = 11'h40A;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < TMO - 2; i++) tick();
    nvec++;
    if (tgt_sel !== 3'b010 || req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL race_pre sel=%b rdy=%b want=010/0",
               tgt_sel, req_ready);
    end
    tick();
    tgt_ack = 3'b010;
    tick();
    tgt_ack = '0;
    nvec++;
    if (req_ready !== 1'b1 || req_err !== 1'b0 || err_count !== 8'd2) begin
      nerr++;
      $display("FAIL race rdy=%b er=%b cnt=%0d want=1/0/2",
               req_ready, req_err, err_count);
    end
    tick();
  endtask

  task automatic test_saturate();
    logic [2:0] sel;
    logic       er;
    int         lat;
    for (int i = 0; i < 256; i++) run(11'h7F0, 3'b000, sel, er, lat);
    nvec++;
    if (err_count !== 8'd255 || err_addr !== 11'h7F0 || er !== 1'b1) begin
      nerr++;
      $display("FAIL saturate cnt=%0d addr=%h er=%b want=255/7f0/1",
               err_count, err_addr, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen;
    req_addr  = 11'h500;
    req_valid = 1'b1;
    tick();
    seen[0] = req_ready;
    tick();
    seen[1] = req_ready;
    tick();
    seen[2] = req_ready;
    req_valid = 1'b0;
    tick();
    nvec++;
    if (seen !== 3'b101 || err_count !== 8'd255) begin
      nerr++;
      $display("FAIL back_to_back rdy=%b cnt=%0d want=101/255",
               seen, err_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] sel;
    logic       er;
    int         lat;
    req_addr  = 11'h005;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    nvec++;
    if (tgt_sel !== 3'b000 || busy !== 1'b0 || req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid sel=%b busy=%b rdy=%b want=000/0/0",
               tgt_sel, busy, req_ready);
    end
    reset = 1'b0;
    tick();
    nvec++;
    if (req_ready !== 1'b0 || err_count !== 8'd0) begin
      nerr++;
      $display("FAIL reset_mid_after rdy=%b cnt=%0d want=0/0",
               req_ready, err_count);
    end
    run(11'h000, 3'b001, sel, er, lat);
    nvec++;
    if (sel !== 3'b001 || er !== 1'b0 || lat != 2) begin
      nerr++;
      $display("FAIL reset_mid_req sel=%b er=%b lat=%0d want=001/0/2",
               sel, er, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_unmapped();
    test_timeout();
    test_race();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
